// File: rtl/xnor_pkg.sv
// Constants and helpers shared by the XNOR popcount datapath.
// The binarize rule and window bit order live here so the packer and the XNOR unit agree.
package xnor_pkg;

  localparam int KERNEL_DEFAULT         = 5;
  localparam int INPUT_BITWIDTH_DEFAULT = KERNEL_DEFAULT * KERNEL_DEFAULT;
  localparam int ACT_MAX_BITWIDTH       = 32;

  // Non-negative activations map to 1, so zero counts as positive.
  function automatic logic sign_bit(input logic signed [ACT_MAX_BITWIDTH-1:0] act);
    return act >= 0;
  endfunction

  function automatic int win_idx(input int r, input int c, input int kernel);
    return r * kernel + c;
  endfunction

endpackage

// File: rtl/xnor_line_buffer.sv
// (KERNEL-1) x IMG_WIDTH bit line buffers: row 0 holds the oldest image row.
// A shift at column col moves that column up one row and inserts the new pixel at the bottom.
module xnor_line_buffer
  import xnor_pkg::*;
#(
  parameter int IMG_WIDTH = 8,
  parameter int KERNEL    = KERNEL_DEFAULT,
  localparam int COL_W    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1
) (
  input  logic             clock,
  input  logic             shift_en,
  input  logic [COL_W-1:0] col,
  input  logic             pix,
  output logic [KERNEL-2:0] col_bits
);

  logic [IMG_WIDTH-1:0] line_mem [KERNEL-1];

  genvar gi;
  generate
    for (gi = 0; gi < KERNEL - 1; gi++) begin : g_read
      assign col_bits[gi] = line_mem[gi][col];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (shift_en) begin
      for (int r = 0; r < KERNEL - 2; r++) begin
        line_mem[r][col] <= line_mem[r+1][col];
      end
      line_mem[KERNEL-2][col] <= pix;
    end
  end

endmodule

// File: rtl/xnor_window_packer.sv
// Binarizes a row-major activation stream and emits packed KERNELxKERNEL windows
// (valid convolution, stride 1) through a single-entry output register.
module xnor_window_packer
  import xnor_pkg::*;
#(
  parameter int IMG_WIDTH      = 8,
  parameter int IMG_HEIGHT     = 8,
  parameter int KERNEL         = KERNEL_DEFAULT,
  parameter int ACT_BITWIDTH   = 8,
  localparam int INPUT_BITWIDTH = KERNEL * KERNEL
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [ACT_BITWIDTH-1:0] in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [INPUT_BITWIDTH-1:0]      out_data,
  output logic                           out_last
);

  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_WIN  = COL_W'(KERNEL - 1);
  localparam logic [ROW_W-1:0] ROW_WIN  = ROW_W'(KERNEL - 1);

  logic [COL_W-1:0]          col_reg;
  logic [ROW_W-1:0]          row_reg;
  logic [INPUT_BITWIDTH-1:0] win_reg;
  logic [INPUT_BITWIDTH-1:0] win_next;
  logic [INPUT_BITWIDTH-1:0] out_data_reg;
  logic                      out_valid_reg;
  logic                      out_last_reg;
  logic                      xfer;
  logic                      pix;
  logic                      completes;
  logic                      at_col_end;
  logic                      at_row_end;
  logic [KERNEL-2:0]         lb_bits;
  logic [KERNEL-1:0]         col_bits;

  assign in_ready   = !out_valid_reg || out_ready;
  assign xfer       = in_valid && in_ready;
  assign pix        = sign_bit(ACT_MAX_BITWIDTH'(in_data));
  assign at_col_end = (col_reg == COL_LAST);
  assign at_row_end = (row_reg == ROW_LAST);
  assign completes  = (row_reg >= ROW_WIN) && (col_reg >= COL_WIN);

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;

  xnor_line_buffer #(
    .IMG_WIDTH (IMG_WIDTH),
    .KERNEL    (KERNEL)
  ) u_line_buffer (
    .clock    (clock),
    .shift_en (xfer),
    .col      (col_reg),
    .pix      (pix),
    .col_bits (lb_bits)
  );

  // Newest column of the window: line buffers above, incoming pixel at the bottom.
  assign col_bits = {pix, lb_bits};

  genvar gi, gj;
  generate
    for (gi = 0; gi < KERNEL; gi++) begin : g_row
      for (gj = 0; gj < KERNEL; gj++) begin : g_col
        localparam int IDX = win_idx(gi, gj, KERNEL);
        if (gj == KERNEL - 1) begin : g_new
          assign win_next[IDX] = col_bits[gi];
        end else begin : g_shift
          assign win_next[IDX] = win_reg[IDX+1];
        end
      end
    end
  endgenerate

  // Window contents are don't-care after reset; stale columns never reach the output.
  always_ff @(posedge clock) begin
    if (xfer) begin
      win_reg <= win_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      col_reg       <= '0;
      row_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
    end else begin
      if (xfer) begin
        if (at_col_end) begin
          col_reg <= '0;
          row_reg <= at_row_end ? '0 : row_reg + ROW_W'(1);
        end else begin
          col_reg <= col_reg + COL_W'(1);
        end
      end
      if (xfer && completes) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= win_next;
        out_last_reg  <= at_col_end && at_row_end;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_xnor_window_packer.sv
// Directed bench: an 8x8 instance for frame-level scenarios, a 5x5 instance for single-window cases.
module tb_xnor_window_packer;

  logic clk = 1'b0;
  logic reset;

  logic              in_valid, in_ready, out_valid, out_ready, out_last;
  logic signed [7:0] in_data;
  logic [24:0]       out_data;

  logic              in_valid5, in_ready5, out_valid5, out_ready5, out_last5;
  logic signed [7:0] in_data5;
  logic [24:0]       out_data5;

  int errors = 0;
  int checks = 0;
  int ready_mode = 0;   // 0: hold low, 1: hold high, 2: toggle each cycle
  logic sender_done;

  logic [24:0] got_d8[$];
  logic        got_l8[$];

  always #5 clk = ~clk;

  xnor_window_packer #(.IMG_WIDTH(8), .IMG_HEIGHT(8), .KERNEL(5), .ACT_BITWIDTH(8)) dut (
    .clock(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  xnor_window_packer #(.IMG_WIDTH(5), .IMG_HEIGHT(5), .KERNEL(5), .ACT_BITWIDTH(8)) dut5 (
    .clock(clk), .reset(reset),
    .in_valid(in_valid5), .in_ready(in_ready5), .in_data(in_data5),
    .out_valid(out_valid5), .out_ready(out_ready5), .out_data(out_data5), .out_last(out_last5)
  );

  // Record each accepted 8x8 window; sampled mid-cycle, so it is the handshake at the next edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      got_d8.push_back(out_data);
      got_l8.push_back(out_last);
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ~out_ready;
      endcase
    end
  end

  function automatic logic signed [7:0] pix_val(input int mode, input int r, input int c);
    case (mode)
      0: return 8'sd0;
      1: return -8'sd1;
      2: return (c == 0) ? 8'sd1 : -8'sd1;
      3: return (((r * 3 + c * 5) % 7) < 3) ? -8'sd5 : 8'sd9;
      default: begin
        if (r == 0 && c == 0) return -8'sd1;
        if (r == 0 && c == 1) return 8'sd0;
        if (r == 0 && c == 2) return -8'sd128;
        if (r == 0 && c == 3) return 8'sd127;
        return -8'sd1;
      end
    endcase
  endfunction

  // Reference window: bit r*5+c is the sign of pixel (wr+r, wc+c).
  function automatic logic [24:0] exp_win(input int mode, input int wr, input int wc);
    logic [24:0] w;
    w = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        w[r*5+c] = (pix_val(mode, wr + r, wc + c) >= 0);
    return w;
  endfunction

  task automatic wait_xfer8();
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      errors++; checks++;
      $display("FAIL xfer8_timeout: in_ready=%0b required 1 within 1000 cycles", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send8(input int mode, input int npix);
    for (int i = 0; i < npix; i++) begin
      in_valid = 1'b1;
      in_data  = pix_val(mode, i / 8, i % 8);
      wait_xfer8();
    end
    in_valid = 1'b0;
  endtask

  task automatic send5(input logic signed [7:0] v);
    int t = 0;
    in_valid5 = 1'b1;
    in_data5  = v;
    @(negedge clk);
    while (!in_ready5 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready5) begin
      errors++; checks++;
      $display("FAIL xfer5_timeout: in_ready5=%0b required 1", in_ready5);
    end
    @(posedge clk);
    #1;
    in_valid5 = 1'b0;
  endtask

  task automatic check_count(input string name, input int want);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (got_d8.size() !== want) begin
      errors++;
      $display("FAIL %s_count: got %0d windows, required %0d", name, got_d8.size(), want);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
    checks++; if (out_data !== 25'h0) begin errors++; $display("FAIL reset_out_data: got %h required 0", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %0b required 0", out_last); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
    checks++; if (out_valid5 !== 1'b0) begin errors++; $display("FAIL reset_out_valid5: got %0b required 0", out_valid5); end
    checks++; if (out_data5 !== 25'h0) begin errors++; $display("FAIL reset_out_data5: got %h required 0", out_data5); end
    checks++; if (out_last5 !== 1'b0) begin errors++; $display("FAIL reset_out_last5: got %0b required 0", out_last5); end
    $display("test_reset: done");
  endtask

  task automatic test_single_window();
    for (int i = 0; i < 24; i++) send5(8'sd0);
    checks++; if (out_valid5 !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %0b required 0", out_valid5); end
    send5(8'sd0);
    checks++; if (out_valid5 !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b required 1", out_valid5); end
    checks++; if (out_data5 !== 25'h1FFFFFF) begin errors++; $display("FAIL single_data: got %h required 1ffffff", out_data5); end
    checks++; if (out_last5 !== 1'b1) begin errors++; $display("FAIL single_last: got %0b required 1", out_last5); end
    @(posedge clk);
    #1;
    checks++; if (out_valid5 !== 1'b0) begin errors++; $display("FAIL single_drain: got %0b required 0", out_valid5); end
    $display("test_single_window: data=%h last=%0b", 25'h1FFFFFF, 1'b1);
  endtask

  task automatic test_binarize();
    for (int i = 0; i < 25; i++) send5(pix_val(4, i / 5, i % 5));
    checks++; if (out_valid5 !== 1'b1) begin errors++; $display("FAIL binarize_valid: got %0b required 1", out_valid5); end
    checks++; if (out_data5 !== 25'h000000A) begin errors++; $display("FAIL binarize_data: got %h required 000000a", out_data5); end
    checks++; if (out_last5 !== 1'b1) begin errors++; $display("FAIL binarize_last: got %0b required 1", out_last5); end
    $display("test_binarize: data=%h", out_data5);
  endtask

  task automatic test_column_pattern();
    logic [24:0] want;
    got_d8.delete(); got_l8.delete();
    ready_mode = 1;
    send8(2, 64);
    check_count("column", 16);
    for (int k = 0; k < 16 && k < got_d8.size(); k++) begin
      want = (k % 4 == 0) ? 25'h0108421 : 25'h0000000;
      checks++;
      if (got_d8[k] !== want) begin errors++; $display("FAIL column_data[%0d]: got %h required %h", k, got_d8[k], want); end
      checks++;
      if (got_l8[k] !== (k == 15)) begin errors++; $display("FAIL column_last[%0d]: got %0b required %0b", k, got_l8[k], k == 15); end
      $display("test_column_pattern: window %0d data=%h", k, got_d8[k]);
    end
  endtask

  task automatic test_backpressure();
    int t = 0;
    got_d8.delete(); got_l8.delete();
    ready_mode = 0;
    sender_done = 1'b0;
    fork
      begin
        send8(3, 64);
        sender_done = 1'b1;
      end
    join_none
    repeat (50) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %0b required 0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %0b required 1", out_valid); end
    checks++; if (out_data !== exp_win(3, 0, 0)) begin errors++; $display("FAIL bp_hold_data: got %h required %h", out_data, exp_win(3, 0, 0)); end
    repeat (5) @(negedge clk);
    checks++; if (out_data !== exp_win(3, 0, 0)) begin errors++; $display("FAIL bp_hold_data_later: got %h required %h", out_data, exp_win(3, 0, 0)); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_later: got %0b required 0", in_ready); end
    ready_mode = 2;
    while (!sender_done && t < 2000) begin
      @(posedge clk);
      t++;
    end
    checks++; if (sender_done !== 1'b1) begin errors++; $display("FAIL bp_sender_timeout: done=%0b required 1", sender_done); end
    ready_mode = 1;
    check_count("bp", 16);
    for (int k = 0; k < 16 && k < got_d8.size(); k++) begin
      checks++;
      if (got_d8[k] !== exp_win(3, k / 4, k % 4)) begin
        errors++; $display("FAIL bp_data[%0d]: got %h required %h", k, got_d8[k], exp_win(3, k / 4, k % 4));
      end
      checks++;
      if (got_l8[k] !== (k == 15)) begin errors++; $display("FAIL bp_last[%0d]: got %0b required %0b", k, got_l8[k], k == 15); end
      $display("test_backpressure: window %0d data=%h", k, got_d8[k]);
    end
  endtask

  task automatic test_reset_midframe();
    ready_mode = 1;
    send8(0, 6 * 8 + 3);
    apply_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %0b required 0", out_valid); end
    got_d8.delete(); got_l8.delete();
    send8(1, 64);
    check_count("midreset", 16);
    for (int k = 0; k < 16 && k < got_d8.size(); k++) begin
      checks++;
      if (got_d8[k] !== 25'h0) begin errors++; $display("FAIL midreset_data[%0d]: got %h required 0000000", k, got_d8[k]); end
      checks++;
      if (got_l8[k] !== (k == 15)) begin errors++; $display("FAIL midreset_last[%0d]: got %0b required %0b", k, got_l8[k], k == 15); end
      $display("test_reset_midframe: window %0d data=%h", k, got_d8[k]);
    end
  endtask

  task automatic test_back_to_back();
    logic [24:0] want;
    got_d8.delete(); got_l8.delete();
    ready_mode = 1;
    send8(0, 64);
    send8(1, 64);
    check_count("b2b", 32);
    for (int k = 0; k < 32 && k < got_d8.size(); k++) begin
      want = (k < 16) ? 25'h1FFFFFF : 25'h0;
      checks++;
      if (got_d8[k] !== want) begin errors++; $display("FAIL b2b_data[%0d]: got %h required %h", k, got_d8[k], want); end
      checks++;
      if (got_l8[k] !== (k == 15 || k == 31)) begin
        errors++; $display("FAIL b2b_last[%0d]: got %0b required %0b", k, got_l8[k], k == 15 || k == 31);
      end
      $display("test_back_to_back: window %0d data=%h last=%0b", k, got_d8[k], got_l8[k]);
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;  in_data = '0;
    in_valid5 = 1'b0; in_data5 = '0;
    out_ready5 = 1'b1;
    sender_done = 1'b0;
    test_reset();
    test_single_window();
    test_binarize();
    test_column_pattern();
    test_backpressure();
    test_reset_midframe();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xnor_window_packer.md
Name: xnor_window_packer

Overview:
- Producer side of the XNOR popcount convolution datapath.
- Accepts a row-major stream of signed activations and binarizes each one to a single bit.
- Keeps KERNEL-1 bit line buffers and slides a KERNEL x KERNEL window over each frame.
- Emits packed KERNEL*KERNEL-bit activation vectors, ready to drive the activation input of the XNOR/bit-count unit. Valid convolution only: no padding, stride 1.

Parameters:
- IMG_WIDTH, 8, pixels per row; must be >= KERNEL
- IMG_HEIGHT, 8, rows per frame; must be >= KERNEL
- KERNEL, 5, window side
- ACT_BITWIDTH, 8, width of the signed input activation
- INPUT_BITWIDTH (derived localparam), KERNEL*KERNEL = 25, width of the packed output

Ports:
- clock, input, 1: single clock, rising edge
- reset, input, 1: synchronous, active-high
- in_valid, input, 1: activation valid
- in_ready, output, 1: packer can accept an activation
- in_data, input, ACT_BITWIDTH: signed activation, row-major order
- out_valid, output, 1: packed window valid
- out_ready, input, 1: consumer accepts the window
- out_data, output, INPUT_BITWIDTH: packed binary window
- out_last, output, 1: qualifies the last window of the frame

Behaviour:
- Reset (synchronous, active-high): out_valid=0, out_data=0, out_last=0; column/row counters=0. Line buffer and window contents are don't-care. Reset mid-frame abandons the frame; the next accepted pixel is (0,0).
- Binarize: bit = 1 if in_data >= 0 (signed), else 0. Examples: 0→1, 127→1, -1→0, -128→0.
- Input handshake: transfer when in_valid && in_ready. in_ready = !out_valid || out_ready (single-entry output register, combinational ready, no bubble under continuous flow).
- On each transfer:
  - The binary pixel at (row,col) shifts into the window's bottom row at column KERNEL-1.
  - Column c of window row r is taken from line buffer r at col (r < KERNEL-1), and from the new pixel at r = KERNEL-1.
  - Line buffers shift up one row at col.
  - The col counter increments; at IMG_WIDTH-1 it wraps to 0 and row increments.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1) both counters wrap to 0, so back-to-back frames need no idle cycle.
- Window emit:
  - If the transfer has row >= KERNEL-1 and col >= KERNEL-1, then next cycle out_valid=1 and out_data holds the window whose bottom-right pixel is (row,col). Latency is 1 cycle from the accepting edge.
  - out_last=1 iff that pixel is (IMG_HEIGHT-1, IMG_WIDTH-1).
  - Windows per frame: (IMG_WIDTH-KERNEL+1)*(IMG_HEIGHT-KERNEL+1); 16 at the defaults.
- Bit order: out_data[r*KERNEL+c] = pixel (wrow+r, wcol+c), where (wrow,wcol) is the window's top-left. Bit 0 is top-left, bit 24 is bottom-right.
- Output hold: out_valid, out_data and out_last stay stable until out_valid && out_ready.
  - A simultaneous drain and a window-completing transfer loads the new window with no gap.
  - A drain with a non-completing transfer clears out_valid.
- Stale data: line-buffer contents from the previous frame are never emitted, because windows only form at row >= KERNEL-1. No clear is needed between frames.
- Non-goals: no padding, no stride > 1, no multi-channel interleave.

Decomposition:
- Shared package xnor_pkg:
  - KERNEL and INPUT_BITWIDTH defaults (same constants the XNOR unit uses)
  - the binarize rule as a function sign_bit(act)
  - the bit-index mapping function win_idx(r,c) = r*KERNEL+c
- One natural sub-module, xnor_line_buffer: a (KERNEL-1) x IMG_WIDTH bit shift array with col-indexed read/shift-in. The top level holds the counters, window register and handshake.

Test Plan:
1. W=H=5, 25 pixels all 0 → exactly one window: out_data=25'h1FFFFFF, out_last=1, one cycle after the 25th transfer.
2. W=H=8, pixel positive iff x==0 (-1 elsewhere) → 16 windows. Window (0,0) = 25'h0108421; every window with wcol>0 = 25'h0000000. out_last only on the 16th.
3. Binarize boundaries: a 5x5 frame with pixel (0,0)=-1, (0,1)=0, (0,2)=-128, (0,3)=127, all others -1 → out_data=25'h000000A.
4. Backpressure: 8x8 frame, out_ready held 0 → after the first window in_ready=0 and out_data stays stable. Then toggle out_ready 1/0 → all 16 windows delivered in order, none lost or duplicated.
5. Reset at row 6, col 3 of an 8x8 frame, then a fresh 8x8 frame → out_valid=0 the cycle after reset. Exactly 16 windows, all computed from the new frame only.
6. Two back-to-back 8x8 frames (all 0, then all -1) with in_valid and out_ready held 1 → 32 windows: the first 16 are 25'h1FFFFFF, the last 16 are 0, and out_last is high on windows 16 and 32.
